// File: rtl/fox_net_pkg.sv
// Shared packet definitions for the fox_net node: width formula, field offsets
// and pack/unpack helpers used by the arbiter, CPU wrapper and router adapter.
package fox_net_pkg;

    localparam int DEF_COORD_BITS           = 1;
    localparam int DEF_MULTICAST_GROUP_BITS = 1;
    localparam int DEF_MATRIX_TYPE_BITS     = 1;
    localparam int DEF_MATRIX_COORD_BITS    = 8;
    localparam int DEF_MATRIX_ELEMENT_BITS  = 32;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic int packet_bits(input int coord, input int group, input int mtype,
                                       input int mcoord, input int element);
        return 2*coord + group + 2 + mtype + 2*mcoord + element;
    endfunction

    localparam int PKT_BITS = packet_bits(DEF_COORD_BITS, DEF_MULTICAST_GROUP_BITS,
                                          DEF_MATRIX_TYPE_BITS, DEF_MATRIX_COORD_BITS,
                                          DEF_MATRIX_ELEMENT_BITS);

    // Field LSB offsets, built upward from matrix_element at bit 0.
    localparam int ELEM_LSB   = 0;
    localparam int MY_LSB     = ELEM_LSB + DEF_MATRIX_ELEMENT_BITS;
    localparam int MX_LSB     = MY_LSB + DEF_MATRIX_COORD_BITS;
    localparam int TYPE_LSB   = MX_LSB + DEF_MATRIX_COORD_BITS;
    localparam int RESULT_BIT = TYPE_LSB + DEF_MATRIX_TYPE_BITS;
    localparam int READY_BIT  = RESULT_BIT + 1;
    localparam int GROUP_LSB  = READY_BIT + 1;
    localparam int Y_LSB      = GROUP_LSB + DEF_MULTICAST_GROUP_BITS;
    localparam int X_LSB      = Y_LSB + DEF_COORD_BITS;

    typedef struct packed {
        logic [DEF_COORD_BITS-1:0]           x_coord;
        logic [DEF_COORD_BITS-1:0]           y_coord;
        logic [DEF_MULTICAST_GROUP_BITS-1:0] multicast_group;
        logic                                ready_flag;
        logic                                result_flag;
        logic [DEF_MATRIX_TYPE_BITS-1:0]     matrix_type;
        logic [DEF_MATRIX_COORD_BITS-1:0]    matrix_x_coord;
        logic [DEF_MATRIX_COORD_BITS-1:0]    matrix_y_coord;
        logic [DEF_MATRIX_ELEMENT_BITS-1:0]  matrix_element;
    } packet_t;

    function automatic logic [PKT_BITS-1:0] pack(input packet_t p);
        logic [PKT_BITS-1:0] v;
        v = '0;
        v[X_LSB +: DEF_COORD_BITS]               = p.x_coord;
        v[Y_LSB +: DEF_COORD_BITS]               = p.y_coord;
        v[GROUP_LSB +: DEF_MULTICAST_GROUP_BITS] = p.multicast_group;
        v[READY_BIT]                             = p.ready_flag;
        v[RESULT_BIT]                            = p.result_flag;
        v[TYPE_LSB +: DEF_MATRIX_TYPE_BITS]      = p.matrix_type;
        v[MX_LSB +: DEF_MATRIX_COORD_BITS]       = p.matrix_x_coord;
        v[MY_LSB +: DEF_MATRIX_COORD_BITS]       = p.matrix_y_coord;
        v[ELEM_LSB +: DEF_MATRIX_ELEMENT_BITS]   = p.matrix_element;
        return v;
    endfunction

    function automatic packet_t unpack(input logic [PKT_BITS-1:0] v);
        return packet_t'(v);
    endfunction

endpackage

// File: rtl/fox_net_hold_reg.sv
// Single-entry packet buffer; ready is the registered empty flag so it never
// depends combinationally on downstream backpressure.
module fox_net_hold_reg #(
    parameter int WIDTH = 54
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_take,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Capture only while empty and take only while full, so the two never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = !r_full;
    assign o_data  = r_data;
    assign o_full  = r_full;

endmodule

// File: rtl/fox_net_tx_arbiter.sv
// Round-robin arbiter sharing one injection port between the CPU packet
// interface (req0) and the ROM/result streamer (req1), with sent counters.
module fox_net_tx_arbiter
    import fox_net_pkg::*;
#(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int COUNT_BITS           = 16,
    localparam int PACKET_BITS = packet_bits(COORD_BITS, MULTICAST_GROUP_BITS,
                                             MATRIX_TYPE_BITS, MATRIX_COORD_BITS,
                                             MATRIX_ELEMENT_BITS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   arb_enable,
    input  logic [PACKET_BITS-1:0] req0_packet,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [PACKET_BITS-1:0] req1_packet,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    output logic [PACKET_BITS-1:0] out_packet,
    output logic                   out_valid,
    output logic                   out_source,
    input  logic                   out_ready,
    input  logic                   count_clear,
    output logic [COUNT_BITS-1:0]  sent_count0,
    output logic [COUNT_BITS-1:0]  sent_count1,
    output logic                   busy
);

    logic [PACKET_BITS-1:0] w_hold0, w_hold1;
    logic                   w_full0, w_full1;
    logic                   w_load_en, w_grant, w_deliver;

    logic [PACKET_BITS-1:0] r_out_packet;
    logic                   r_out_valid;
    logic                   r_out_source;
    logic                   r_last_grant;
    logic [COUNT_BITS-1:0]  r_count0, r_count1;

    fox_net_hold_reg #(.WIDTH(PACKET_BITS)) u_hold0 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (req0_packet),
        .i_valid (req0_valid),
        .o_ready (req0_ready),
        .i_take  (w_load_en && (w_grant == REQ0)),
        .o_data  (w_hold0),
        .o_full  (w_full0)
    );

    fox_net_hold_reg #(.WIDTH(PACKET_BITS)) u_hold1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (req1_packet),
        .i_valid (req1_valid),
        .o_ready (req1_ready),
        .i_take  (w_load_en && (w_grant == REQ1)),
        .o_data  (w_hold1),
        .o_full  (w_full1)
    );

    assign w_load_en = arb_enable && (!r_out_valid || out_ready) && (w_full0 || w_full1);
    // With both full, alternate away from the previous winner; otherwise take whichever is full.
    assign w_grant   = (w_full0 && w_full1) ? !r_last_grant : w_full1;
    assign w_deliver = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_packet <= '0;
            r_out_valid  <= 1'b0;
            r_out_source <= REQ0;
            r_last_grant <= REQ1;
        end else if (w_load_en) begin
            r_out_packet <= (w_grant == REQ1) ? w_hold1 : w_hold0;
            r_out_valid  <= 1'b1;
            r_out_source <= w_grant;
            r_last_grant <= w_grant;
        end else if (w_deliver) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else if (count_clear) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else if (w_deliver) begin
            if (r_out_source == REQ0) r_count0 <= r_count0 + COUNT_BITS'(1);
            else                      r_count1 <= r_count1 + COUNT_BITS'(1);
        end
    end

    assign out_packet  = r_out_packet;
    assign out_valid   = r_out_valid;
    assign out_source  = r_out_source;
    assign sent_count0 = r_count0;
    assign sent_count1 = r_count1;
    assign busy        = w_full0 | w_full1 | r_out_valid;

endmodule

// File: tb/tb_fox_net_tx_arbiter.sv
// Self-checking bench for fox_net_tx_arbiter: directed scenarios plus a
// transaction scoreboard that follows every accepted and delivered packet.
module tb_fox_net_tx_arbiter;

    localparam int PW = 54;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arb_enable;
    logic [PW-1:0] req0_packet, req1_packet;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [PW-1:0] out_packet;
    logic          out_valid, out_source, out_ready;
    logic          count_clear;
    logic [CB-1:0] sent_count0, sent_count1;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: per-source in-order packet queues and wrapping counts.
    logic [PW-1:0] q0[$];
    logic [PW-1:0] q1[$];
    logic          src_log[$];
    logic [CB-1:0] m_cnt0, m_cnt1;
    logic [PW-1:0] m_exp;

    fox_net_tx_arbiter #(.COUNT_BITS(CB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arb_enable  (arb_enable),
        .req0_packet (req0_packet),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req1_packet (req1_packet),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .out_packet  (out_packet),
        .out_valid   (out_valid),
        .out_source  (out_source),
        .out_ready   (out_ready),
        .count_clear (count_clear),
        .sent_count0 (sent_count0),
        .sent_count1 (sent_count1),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Inputs change only 1 time unit after posedge, so negedge sees what the next edge will see.
    always @(negedge clk) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            checks++;
            if ({sent_count0, sent_count1} !== {m_cnt0, m_cnt1}) begin
                errors++;
                $display("FAIL counters: got %0d/%0d want %0d/%0d",
                         sent_count0, sent_count1, m_cnt0, m_cnt1);
            end
            if (req0_valid && req0_ready) q0.push_back(req0_packet);
            if (req1_valid && req1_ready) q1.push_back(req1_packet);
            if (out_valid && out_ready) begin
                src_log.push_back(out_source);
                checks++;
                if ((out_source ? q1.size() : q0.size()) == 0) begin
                    errors++;
                    $display("FAIL delivery_dup: source %0d delivered %h with nothing pending",
                             out_source, out_packet);
                end else begin
                    m_exp = out_source ? q1.pop_front() : q0.pop_front();
                    if (out_packet !== m_exp) begin
                        errors++;
                        $display("FAIL delivery_data: source %0d got %h want %h",
                                 out_source, out_packet, m_exp);
                    end
                end
                if (!count_clear) begin
                    if (out_source) m_cnt1 = m_cnt1 + 1'b1;
                    else            m_cnt0 = m_cnt0 + 1'b1;
                end
            end
            if (count_clear) begin
                m_cnt0 = '0;
                m_cnt1 = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        return PW'({$urandom(), $urandom()});
    endfunction

    task automatic send(input int r, input logic [PW-1:0] p);
        logic acc;
        acc = 1'b0;
        if (r == 0) begin req0_packet = p; req0_valid = 1'b1; end
        else        begin req1_packet = p; req1_valid = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            acc = (r == 0) ? req0_ready : req1_ready;
            step();
            if (acc) break;
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: requester %0d never accepted", r);
        end
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin step(); n++; end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_valid: out_valid got 0 want 1", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 30) begin step(); n++; end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_idle: busy got 1 want 0", tag);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({req0_ready, req1_ready, out_valid, out_source, busy} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 11000",
                     {req0_ready, req1_ready, out_valid, out_source, busy});
        end
        checks++;
        if ({out_packet, sent_count0, sent_count1} !== '0) begin
            errors++;
            $display("FAIL reset_data: got pkt %h cnt %0d/%0d want zeros",
                     out_packet, sent_count0, sent_count1);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        p = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0000_0011};
        out_ready = 1'b1;
        req0_packet = p;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        checks++;
        if ({out_valid, req0_ready} !== 2'b00) begin
            errors++;
            $display("FAIL single_n1: valid/ready got %b want 00", {out_valid, req0_ready});
        end
        step();
        checks++;
        if ({out_valid, out_source, out_packet} !== {1'b1, 1'b0, p}) begin
            errors++;
            $display("FAIL single_n2: got v=%b s=%b pkt=%h want v=1 s=0 pkt=%h",
                     out_valid, out_source, out_packet, p);
        end
        step();
        checks++;
        if ({sent_count0, out_valid} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_count: got cnt0=%0d v=%b want 1 0", sent_count0, out_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        src_log.delete();
        out_ready = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send(0, rand_pkt());
            for (int i = 0; i < 4; i++) send(1, rand_pkt());
        join
        wait_idle("contention");
        checks++;
        if (src_log.size() != 8) begin
            errors++;
            $display("FAIL contention_count: got %0d deliveries want 8", src_log.size());
        end
        for (int i = 0; i < src_log.size() && i < 8; i++) begin
            checks++;
            if (src_log[i] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %0d want %0d", i, src_log[i], i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p0, snap;
        p0 = rand_pkt();
        src_log.delete();
        out_ready = 1'b0;
        send(0, p0);
        wait_out_valid("backpressure");
        fork
            send(1, rand_pkt());
            send(0, rand_pkt());
        join
        snap = out_packet;
        checks++;
        if (snap !== p0) begin
            errors++;
            $display("FAIL bp_first: got %h want %h", snap, p0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, out_source, out_packet} !== {1'b1, 1'b0, snap}) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got v=%b s=%b pkt=%h want v=1 s=0 pkt=%h",
                         i, out_valid, out_source, out_packet, snap);
            end
        end
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL bp_ready: got %b want 001", {req0_ready, req1_ready, busy});
        end
        out_ready = 1'b1;
        wait_idle("backpressure");
        checks++;
        if (src_log.size() != 3 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d delivered, %0d/%0d pending want 3, 0/0",
                     src_log.size(), q0.size(), q1.size());
        end else begin
            checks++;
            if ({src_log[0], src_log[1], src_log[2]} !== 3'b010) begin
                errors++;
                $display("FAIL bp_order: got %b want 010", {src_log[0], src_log[1], src_log[2]});
            end
        end
    endtask

    task automatic test_enable();
        logic [PW-1:0] p;
        p = rand_pkt();
        arb_enable = 1'b0;
        out_ready = 1'b1;
        send(1, p);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req1_ready, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL enable_gated[%0d]: ready/valid got %b want 00", i, {req1_ready, out_valid});
            end
            step();
        end
        arb_enable = 1'b1;
        step();
        checks++;
        if ({out_valid, out_source, out_packet} !== {1'b1, 1'b1, p}) begin
            errors++;
            $display("FAIL enable_release: got v=%b s=%b pkt=%h want v=1 s=1 pkt=%h",
                     out_valid, out_source, out_packet, p);
        end
        step();
    endtask

    task automatic test_counter_wrap();
        out_ready = 1'b1;
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        for (int i = 0; i < 5; i++) send(0, rand_pkt());
        wait_idle("wrap");
        checks++;
        if (sent_count0 !== 2'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 1", sent_count0);
        end
        send(0, rand_pkt());
        wait_out_valid("clear");
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        checks++;
        if ({sent_count0, out_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear_priority: got cnt0=%0d v=%b want 0 0", sent_count0, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(0, rand_pkt());
        wait_out_valid("reset_mid");
        fork
            send(0, rand_pkt());
            send(1, rand_pkt());
        join
        checks++;
        if ({out_valid, req0_ready, req1_ready, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b want 1001", {out_valid, req0_ready, req1_ready, busy});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, out_valid, out_source, busy, out_packet, sent_count0, sent_count1}
            !== {5'b11000, {PW{1'b0}}, {CB{1'b0}}, {CB{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_async: got flags %b pkt %h cnt %0d/%0d want 11000 0 0/0",
                     {req0_ready, req1_ready, out_valid, out_source, busy},
                     out_packet, sent_count0, sent_count1);
        end
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_stale[%0d]: valid/busy got %b want 00", i, {out_valid, busy});
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        arb_enable  = 1'b1;
        req0_packet = '0;
        req1_packet = '0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        out_ready   = 1'b1;
        count_clear = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_enable();
        test_counter_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fox_net_tx_arbiter.md
Name: fox_net_tx_arbiter

Overview:
- Shares one node's network injection port between two packet sources: requester 0 (the PicoRV32 memory-mapped packet interface) and requester 1 (the matrix-init ROM / result streamer).
- Each requester presents a complete packet on a flattened bus with a valid/ready handshake.
- The block buffers one packet per requester, grants round-robin and drives a registered output to the router's injection port with backpressure.
- It also keeps per-requester sent-packet counters for firmware and bench visibility.

Parameters:
- COORD_BITS, 1, router X/Y coordinate width.
- MULTICAST_GROUP_BITS, 1, multicast group field width.
- MATRIX_TYPE_BITS, 1, matrix type field width.
- MATRIX_COORD_BITS, 8, matrix x/y coordinate width.
- MATRIX_ELEMENT_BITS, 32, matrix element width.
- COUNT_BITS, 16, width of each sent-packet counter.
- PACKET_BITS, derived = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- arb_enable  in  1  when 0, no new grants are made.
- req0_packet  in  PACKET_BITS  requester 0 packet.
- req0_valid  in  1  requester 0 packet valid.
- req0_ready  out  1  requester 0 holding register empty.
- req1_packet  in  PACKET_BITS  requester 1 packet.
- req1_valid  in  1  requester 1 packet valid.
- req1_ready  out  1  requester 1 holding register empty.
- out_packet  out  PACKET_BITS  packet to the router.
- out_valid  out  1  out_packet valid.
- out_source  out  1  requester index of out_packet.
- out_ready  in  1  router accepts out_packet.
- count_clear  in  1  synchronous clear of both counters.
- sent_count0  out  COUNT_BITS  packets delivered from requester 0.
- sent_count1  out  COUNT_BITS  packets delivered from requester 1.
- busy  out  1  any holding register or the output register is full.

Behaviour:
- Reset: every output register and all internal state clear asynchronously.
  - req0_ready = req1_ready = 1.
  - out_valid = 0, out_packet = 0, out_source = 0.
  - Counters = 0, last_grant = 1, so requester 0 wins the first tie.
  - busy = 0.
  - Reset mid-transfer drops all buffered packets; no partial packet survives.
- Holding registers (hold0, hold1), one per requester:
  - reqN_ready = !holdN_full; it is a registered flag, never a combinational function of out_ready.
  - On reqN_valid && reqN_ready the packet is captured and holdN_full is set the next cycle.
  - A requester therefore sustains at most one packet per 2 cycles.
  - Packet contents are never modified.
- Output register load condition: load_en = arb_enable && (!out_valid || out_ready) && (hold0_full || hold1_full).
- Grant rules:
  - Only one holding register full: grant it.
  - Both full: grant !last_grant.
  - On load: out_packet and out_source take the winner's values, out_valid is set, the winner's holdN_full clears and last_grant takes the winner's index.
- Simultaneous events:
  - If a holding register empties in the same cycle it is granted, it can accept a new packet from the following cycle (reqN_ready rises the cycle after the grant).
  - Output accept and reload in the same cycle are allowed, giving back-to-back out_valid with no bubble.
- out_valid clears when out_ready && out_valid && !load_en.
- Holding rule: while out_valid && !out_ready, out_packet and out_source stay stable.
- Latency: request accept at cycle N, then out_valid at N+2 if the output is free.
- arb_enable = 0:
  - An in-flight output packet still completes.
  - Holding registers still accept packets; nothing new is granted.
- Counters:
  - sent_countN increments on out_valid && out_ready && out_source == N.
  - Counters wrap modulo 2^COUNT_BITS.
  - count_clear has priority over an increment in the same cycle.
- busy = hold0_full | hold1_full | out_valid.
- Packet packing, MSB to LSB: x_coord, y_coord, multicast_group, ready_flag, result_flag, matrix_type, matrix_x_coord, matrix_y_coord, matrix_element.
- No state machine beyond the per-register full flags and last_grant; fairness is guaranteed because a continuously full holding register waits at most one grant.

Decomposition:
- Shared package/include fox_net_pkg.vh holds:
  - the PACKET_BITS formula;
  - field offset localparams following the packing order;
  - pack and unpack functions, which the CPU-side wrapper and the router adapter also use.
- Natural sub-module: fox_net_hold_reg, the single-entry buffer with valid/ready, instantiated twice.
- The arbiter and output register stay in the top.

Test Plan:
- Single requester:
  - Stimulus: req0 sends element 0x0000_0011 with x=1, y=0, out_ready tied 1.
  - Required: out_valid at accept+2, out_source=0, out_packet matches bit-exact, sent_count0=1.
- Contention:
  - Stimulus: both requesters hold valid continuously, 4 packets each, out_ready=1.
  - Required: out_source alternates 0,1,0,1…; both counters end at 4.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a packet loaded.
  - Required: out_packet and out_valid stable throughout; both req_ready fall once the holds fill; delivery resumes with no loss or duplication.
- Enable gating:
  - Stimulus: arb_enable=0 and req1 sends.
  - Required: req1_ready drops and out_valid stays 0; after arb_enable=1 the packet is delivered the next cycle.
- Counter wrap/clear:
  - Stimulus: COUNT_BITS=2 with 5 deliveries from requester 0.
  - Required: sent_count0=1.
  - Stimulus: count_clear asserted together with a delivery.
  - Required: count reads 0.
- Reset mid-operation:
  - Stimulus: reset_n asserted while out_valid=1 and both holds are full.
  - Required: all outputs are at reset values immediately (asynchronous); no stale packet appears after release.
